// File: rtl/snake_frame_writer.sv
// Double-buffered producer of the 996-bit snake_data frame: writes fill a shadow copy, which is published at VS start.
// Optional build macro SNAKE_FRAME_COUNT_EN replaces word 9 with a swap counter.
//
// state     | meaning
// ----------+-----------------------------------------------------
// S_IDLE    | accept writes into the shadow, wait for commit
// S_PENDING | writes blocked, wait for VS falling edge
// S_SWAP    | publish shadow to snake_data, pulse swap_done
module snake_frame_writer #(
  parameter int          BOARD_CELLS = 1600,
  parameter logic [10:0] OFF_BOARD   = 11'h7FF
) (
  input  logic         iVGA_CLK,
  input  logic         iRST_n,
  input  logic         iVS,
  input  logic         wr_valid,
  output logic         wr_ready,
  input  logic [5:0]   wr_addr,
  input  logic [31:0]  wr_data,
  input  logic         commit,
  output logic [995:0] snake_data,
  output logic         swap_done,
  output logic         addr_err
);

  typedef enum logic [1:0] {S_IDLE, S_PENDING, S_SWAP} state_t;

  function automatic logic [995:0] f_reset_frame();
    logic [995:0] f;
    f = '0;
    f[231:200] = '1;
    f[263:232] = '1;
    f[455:424] = '1;
    f[835:804] = '1;
    for (int i = 0; i < 20; i++) f[520 + 11*i +: 11] = OFF_BOARD;
    return f;
  endfunction

  localparam logic [995:0] RESET_FRAME = f_reset_frame();

  // The sentinel must never alias a real board position.
  if (int'(OFF_BOARD) < BOARD_CELLS) begin : g_bad_off_board
    $error("OFF_BOARD collides with a valid board position");
  end

  state_t         r_state;
  logic           r_vs_d;
  logic           r_wr_ready;
  logic           r_swap_done;
  logic           r_addr_err;
  logic [995:0]   r_shadow;
  logic [995:0]   r_snake_data;
  logic [995:0]   w_publish;
  logic           w_accept;
  logic           w_vs_start;
  logic           w_hit;
  logic           w_seg;
  logic [9:0]     w_base;
  logic [9:0]     w_idx10;
  logic [9:0]     w_seg_off;
  logic [3:0]     w_word_off;

  assign wr_ready   = r_wr_ready;
  assign swap_done  = r_swap_done;
  assign addr_err   = r_addr_err;
  assign snake_data = r_snake_data;

  assign w_accept   = wr_valid & r_wr_ready;
  assign w_vs_start = r_vs_d & ~iVS;
  assign w_idx10    = {6'd0, wr_addr[3:0]};
  assign w_seg_off  = (w_idx10 << 3) + (w_idx10 << 1) + w_idx10;
  assign w_word_off = wr_addr[3:0] - 4'd10;

  always_comb begin
    w_hit  = 1'b0;
    w_seg  = 1'b0;
    w_base = '0;
    if (wr_addr < 6'd10) begin
      w_hit  = 1'b1;
      w_base = 10'd200 + {1'b0, wr_addr[3:0], 5'd0};
`ifdef SNAKE_FRAME_COUNT_EN
      if (wr_addr == 6'd9) w_hit = 1'b0;
`endif
    end else if (wr_addr <= 6'd14) begin
      w_hit  = 1'b1;
      w_base = 10'd740 + {1'b0, w_word_off, 5'd0};
    end else if (wr_addr[5:4] == 2'b01 && wr_addr[3:0] <= 4'd9) begin
      w_hit  = 1'b1;
      w_seg  = 1'b1;
      w_base = 10'd520 + w_seg_off;
    end else if (wr_addr[5:4] == 2'b10 && wr_addr[3:0] <= 4'd9) begin
      w_hit  = 1'b1;
      w_seg  = 1'b1;
      w_base = 10'd630 + w_seg_off;
    end
  end

`ifdef SNAKE_FRAME_COUNT_EN
  logic [31:0] r_frame_cnt;
  logic [31:0] w_cnt_next;
  assign w_cnt_next = r_frame_cnt + 32'd1;

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n)                r_frame_cnt <= '0;
    else if (r_state == S_SWAP) r_frame_cnt <= w_cnt_next;
  end

  always_comb begin
    w_publish          = r_shadow;
    w_publish[519:488] = w_cnt_next;
  end
`else
  assign w_publish = r_shadow;
`endif

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_shadow   <= RESET_FRAME;
      r_addr_err <= 1'b0;
    end else if (w_accept) begin
      if (!w_hit)     r_addr_err                <= 1'b1;
      else if (w_seg) r_shadow[w_base +: 11]    <= wr_data[10:0];
      else            r_shadow[w_base +: 32]    <= wr_data;
    end
  end

  // wr_ready stays low for one extra IDLE cycle after SWAP.
  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state      <= S_IDLE;
      r_vs_d       <= 1'b0;
      r_wr_ready   <= 1'b1;
      r_swap_done  <= 1'b0;
      r_snake_data <= RESET_FRAME;
    end else begin
      r_vs_d      <= iVS;
      r_swap_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_wr_ready <= ~commit;
          if (commit) r_state <= S_PENDING;
        end
        S_PENDING: begin
          r_wr_ready <= 1'b0;
          if (w_vs_start) r_state <= S_SWAP;
        end
        S_SWAP: begin
          r_snake_data <= w_publish;
          r_swap_done  <= 1'b1;
          r_wr_ready   <= 1'b0;
          r_state      <= S_IDLE;
        end
        default: begin
          r_state    <= S_IDLE;
          r_wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_snake_frame_writer.sv
// Directed bench for snake_frame_writer: table of word/segment writes plus hand sequences for swap timing corners.
module tb_snake_frame_writer;

  logic         iVGA_CLK = 1'b0;
  logic         iRST_n   = 1'b0;
  logic         iVS      = 1'b1;
  logic         wr_valid = 1'b0;
  logic [5:0]   wr_addr  = '0;
  logic [31:0]  wr_data  = '0;
  logic         commit   = 1'b0;
  logic         wr_ready;
  logic         swap_done;
  logic         addr_err;
  logic [995:0] snake_data;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [5:0]  addr;
    logic [31:0] data;
    int          lo;
    int          w;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  snake_frame_writer dut (
    .iVGA_CLK   (iVGA_CLK),
    .iRST_n     (iRST_n),
    .iVS        (iVS),
    .wr_valid   (wr_valid),
    .wr_ready   (wr_ready),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .commit     (commit),
    .snake_data (snake_data),
    .swap_done  (swap_done),
    .addr_err   (addr_err)
  );

  always #5 iVGA_CLK = ~iVGA_CLK;

  task automatic tick();
    @(posedge iVGA_CLK);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] fld(input int lo, input int w);
    logic [995:0] s;
    logic [31:0]  v;
    s = snake_data >> lo;
    v = s[31:0];
    if (w < 32) v = v & ((32'h1 << w) - 32'h1);
    return v;
  endfunction

  task automatic wr(input logic [5:0] a, input logic [31:0] d);
    int n;
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    n = 0;
    while (!wr_ready && n < 20) begin
      tick();
      n++;
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL wr_timeout addr %0d ready stuck %b expected 1", a, wr_ready);
    end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    tick();
    commit = 1'b0;
  endtask

  task automatic vs_frame(output int pulses);
    pulses = 0;
    iVS = 1'b0;
    repeat (5) begin
      tick();
      if (swap_done) pulses++;
    end
    iVS = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int p, p2;

    vecs.push_back('{6'd0,  32'h0000_0123, 200, 32, 32'h0000_0123});
    vecs.push_back('{6'd5,  32'hDEAD_BEEF, 360, 32, 32'hDEAD_BEEF});
`ifndef SNAKE_FRAME_COUNT_EN
    vecs.push_back('{6'd9,  32'hA5A5_0009, 488, 32, 32'hA5A5_0009});
`endif
    vecs.push_back('{6'd10, 32'h1111_2222, 740, 32, 32'h1111_2222});
    vecs.push_back('{6'd14, 32'h0BAD_F00D, 868, 32, 32'h0BAD_F00D});
    vecs.push_back('{6'd16, 32'hFFFF_F000, 520, 11, 32'h0000_0000});
    vecs.push_back('{6'd25, 32'h0000_0555, 619, 11, 32'h0000_0555});
    vecs.push_back('{6'd32, 32'h0000_07FE, 630, 11, 32'h0000_07FE});
    vecs.push_back('{6'd41, 32'hFFFF_F801, 729, 11, 32'h0000_0001});

    repeat (2) tick();
    iRST_n = 1'b1;
    tick();

    chk("rst_head1pos",  fld(200, 32), 32'hFFFF_FFFF);
    chk("rst_head2pos",  fld(232, 32), 32'hFFFF_FFFF);
    chk("rst_seg1_0",    fld(520, 11), 32'h0000_07FF);
    chk("rst_seg2_9",    fld(729, 11), 32'h0000_07FF);
    chk("rst_stage",     fld(328, 32), 32'h0);
    chk("rst_invpos",    fld(804, 32), 32'hFFFF_FFFF);
    chk("rst_wr_ready",  32'(wr_ready),  32'd1);
    chk("rst_swap_done", 32'(swap_done), 32'd0);
    chk("rst_addr_err",  32'(addr_err),  32'd0);

    wr(6'd4, 32'd2);
    wr(6'd7, 32'd425);
    do_commit();
    chk("ready_low_after_commit", 32'(wr_ready), 32'd0);
    repeat (3) tick();
    chk("pending_no_pulse", 32'(swap_done), 32'd0);
    chk("pending_stage_held", fld(328, 32), 32'h0);
    iVS = 1'b0;
    tick();
    chk("swap_state_no_pulse", 32'(swap_done), 32'd0);
    chk("swap_state_apple_held", fld(424, 32), 32'hFFFF_FFFF);
    tick();
    chk("pulse_high", 32'(swap_done), 32'd1);
    chk("pulse_stage", fld(328, 32), 32'd2);
    chk("pulse_apple", fld(424, 32), 32'd425);
    chk("ready_gap", 32'(wr_ready), 32'd0);
    tick();
    chk("pulse_single", 32'(swap_done), 32'd0);
    chk("ready_back", 32'(wr_ready), 32'd1);
    iVS = 1'b1;
    tick();

    vs_frame(p);
    chk("vs_idle_no_swap", 32'(p), 32'd0);

    wr(6'd17, 32'h123);
    do_commit();
    wr_valid = 1'b1;
    wr_addr  = 6'd17;
    wr_data  = 32'h456;
    tick();
    chk("ready_blocks_pending", 32'(wr_ready), 32'd0);
    vs_frame(p);
    wr_valid = 1'b0;
    chk("held_swap_pulses", 32'(p), 32'd1);
    chk("held_not_in_swap", fld(531, 11), 32'h123);
    do_commit();
    vs_frame(p);
    chk("held_write_later", fld(531, 11), 32'h456);

    do_commit();
    tick();
    do_commit();
    vs_frame(p);
    vs_frame(p2);
    chk("double_commit_one_pulse", 32'(p + p2), 32'd1);

    wr(6'd3, 32'd5);
    wr(6'd3, 32'd7);
    do_commit();
    vs_frame(p);
    chk("last_write_wins", fld(296, 32), 32'd7);

    wr_valid = 1'b1;
    wr_addr  = 6'd8;
    wr_data  = 32'h00C0_FFEE;
    commit   = 1'b1;
    tick();
    wr_valid = 1'b0;
    commit   = 1'b0;
    vs_frame(p);
    chk("write_with_commit", fld(456, 32), 32'h00C0_FFEE);

    for (int i = 0; i < vecs.size(); i++) begin
      wr(vecs[i].addr, vecs[i].data);
      do_commit();
      vs_frame(p);
      chk($sformatf("vec%0d_pulses", i), 32'(p), 32'd1);
      chk($sformatf("vec%0d_addr%0d", i, vecs[i].addr), fld(vecs[i].lo, vecs[i].w), vecs[i].exp);
      chk($sformatf("vec%0d_no_err", i), 32'(addr_err), 32'd0);
    end
    chk("shadow_retained_stage", fld(328, 32), 32'd2);

    wr(6'd50, 32'hFFFF_FFFF);
    chk("unmapped_err", 32'(addr_err), 32'd1);
    do_commit();
    vs_frame(p);
    chk("unmapped_err_sticky", 32'(addr_err), 32'd1);
    chk("unmapped_stage",  fld(328, 32), 32'd2);
    chk("unmapped_apple",  fld(424, 32), 32'd425);
    chk("unmapped_seg1_1", fld(531, 11), 32'h456);
    chk("low_zero",        fld(168, 32), 32'h0);
    chk("high_zero_a",     fld(900, 32), 32'h0);
    chk("high_zero_b",     fld(964, 32), 32'h0);

    wr(6'd4, 32'd9);
    do_commit();
    tick();
    iRST_n = 1'b0;
    #2;
    chk("midrst_stage",    fld(328, 32), 32'h0);
    chk("midrst_apple",    fld(424, 32), 32'hFFFF_FFFF);
    chk("midrst_ready",    32'(wr_ready), 32'd1);
    chk("midrst_addr_err", 32'(addr_err), 32'd0);
    tick();
    iRST_n = 1'b1;
    tick();
    vs_frame(p);
    chk("midrst_commit_lost", 32'(p), 32'd0);
    do_commit();
    vs_frame(p);
    chk("midrst_shadow_stage", fld(328, 32), 32'h0);
    chk("midrst_shadow_seg",   fld(520, 11), 32'h7FF);

`ifdef SNAKE_FRAME_COUNT_EN
    repeat (2) begin
      do_commit();
      vs_frame(p);
    end
    chk("frame_count_3", fld(488, 32), 32'd3);
    wr(6'd9, 32'h1234_5678);
    chk("addr9_err", 32'(addr_err), 32'd1);
    do_commit();
    vs_frame(p);
    chk("frame_count_4", fld(488, 32), 32'd4);
`else
    chk("spare_reset", fld(488, 32), 32'h0);
    wr(6'd9, 32'h1234_5678);
    do_commit();
    vs_frame(p);
    chk("spare_word", fld(488, 32), 32'h1234_5678);
    chk("addr9_no_err", 32'(addr_err), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
